rv32i_hazard_ctrl: RTL and testbench
====================================

Name: rv32i_hazard_ctrl

Overview:
- Pipeline hazard controller for the 5-stage RV32I core; it sits beside the operand-forwarding unit.
- Detects load-use hazards, taken-branch redirects, multi-cycle MDU ops in EX and data-memory wait states.
- Drives per-stage enable and flush controls for the PC, IF/ID, ID/EX and EX/MEM registers.
- Forwarding covers the remaining RAW cases; this block covers only hazards forwarding cannot resolve.

Parameters:
- MDU_TIMEOUT, 64, max cycles in MDU_BUSY before forced abort (must be >= 2).
- TCW, 7, width of the internal timeout counter (must hold MDU_TIMEOUT).

Ports:
- clk  input  1  core clock, rising edge.
- rst_n  input  1  asynchronous active-low reset.
- rs1_id  input  5  rs1 of the instruction in ID.
- rs2_id  input  5  rs2 of the instruction in ID.
- use_rs1_id  input  1  ID instruction reads rs1.
- use_rs2_id  input  1  ID instruction reads rs2.
- rd_ex  input  5  destination register in EX.
- memread_ex  input  1  EX instruction is a load.
- branch_taken_ex  input  1  EX resolved a taken branch or jump.
- mdu_start_ex  input  1  EX holds a mul/div op that needs a multi-cycle unit.
- mdu_done  input  1  MDU result valid (1-cycle pulse).
- dmem_req_mem  input  1  MEM stage issuing a data access.
- dmem_ready  input  1  data memory accepts or completes the access this cycle.
- pc_en  output  1  PC register load enable.
- ifid_en  output  1  IF/ID register enable.
- ifid_flush  output  1  IF/ID register loads a NOP.
- idex_en  output  1  ID/EX register enable.
- idex_flush  output  1  ID/EX register loads a bubble.
- exmem_en  output  1  EX/MEM register enable.
- exmem_flush  output  1  EX/MEM register loads a bubble.
- mdu_err  output  1  1-cycle pulse on MDU timeout.
- perf_loaduse  output  32  load-use stall cycles (optional feature).
- perf_mdu  output  32  MDU stall cycles (optional feature).
- perf_flush  output  32  branch flush events (optional feature).

Behaviour:
- Outputs decode combinationally from the registered state and current inputs.
- State machine, state and timeout counter in flops, reset asynchronously by rst_n low.
  - States: RUN, MDU_BUSY, DMEM_WAIT. Reset -> RUN, counter = 0, mdu_err = 0.
  - During reset all enables read 1 and all flushes read 0.
- Load-use hazard (LU) = memread_ex & rd_ex!=0 & ((use_rs1_id & rd_ex==rs1_id) | (use_rs2_id & rd_ex==rs2_id)).
- Priority in RUN, highest first:
  1. dmem_req_mem & !dmem_ready: all enables 0, no flushes; next state DMEM_WAIT.
  2. branch_taken_ex: ifid_flush = 1, idex_flush = 1, all enables 1; stay in RUN. A branch masks any LU in the same cycle.
  3. mdu_start_ex: pc_en = ifid_en = idex_en = 0, exmem_flush = 1; next state MDU_BUSY, counter cleared to 0.
  4. LU: pc_en = ifid_en = 0, idex_flush = 1, exmem_en = 1. Exactly one bubble; the next cycle re-evaluates normally.
  5. Otherwise: all enables 1, no flushes.
- DMEM_WAIT:
  - All enables 0 until dmem_ready = 1.
  - On the dmem_ready cycle, enables return to 1 and the RUN rules for that cycle's inputs apply (rules 2-5); next state RUN.
- MDU_BUSY:
  - pc_en, ifid_en, idex_en = 0; exmem_flush = 1; counter increments by 1 each cycle.
  - On mdu_done: exmem_en = 1, exmem_flush = 0 (result captured); the other enables stay 0 this cycle; next state RUN.
  - Counter reaches MDU_TIMEOUT-1 without mdu_done: mdu_err pulses 1 on the following cycle; same release as mdu_done; next state RUN.
  - mdu_done and the timeout in the same cycle: done wins, no mdu_err.
  - mdu_done while in RUN is ignored.
- Reset asserted mid-stall returns to RUN immediately, with no pending bubble or flush.

Optional Feature:
- Macro: HAZARD_PERF_CNT_EN.
- Defined:
  - perf_loaduse increments every cycle rule 4 fires.
  - perf_mdu increments every cycle in MDU_BUSY.
  - perf_flush increments on every rule-2 event.
  - All three are 32-bit, wrap 0xFFFFFFFF -> 0, and reset to 0.
- Undefined: all three ports are tied to 0 and no counter flops are generated.

Test Plan:
- Load-use: memread_ex = 1, rd_ex = 5, rs1_id = 5, use_rs1_id = 1 -> for one cycle pc_en = 0, ifid_en = 0, idex_flush = 1; the next cycle, with the load gone, all enables are 1. Repeat with rd_ex = 0 -> no stall.
- Branch vs load-use: the same LU inputs plus branch_taken_ex = 1 -> ifid_flush = idex_flush = 1, pc_en = 1; perf_flush += 1, perf_loaduse unchanged.
- MDU: mdu_start_ex pulse, mdu_done after 5 cycles -> pc_en = 0 for 6 cycles total, exmem_en = 1 with exmem_flush = 0 on the done cycle, state back to RUN; perf_mdu = 5.
- MDU timeout: MDU_TIMEOUT = 4, no mdu_done -> exactly one mdu_err pulse, pipeline released after 4 busy cycles. A done arriving on the timeout cycle -> no mdu_err.
- DMEM wait: dmem_req_mem = 1, dmem_ready = 0 for 3 cycles -> all enables 0 for 3 cycles. Ready arrives together with branch_taken_ex -> flushes asserted that cycle.
- Reset mid-MDU: rst_n low for 1 cycle during MDU_BUSY -> all enables 1 and flushes 0 while low; state RUN afterward; no mdu_err.

Source files
------------

// File: rtl/rv32i_hazard_ctrl.sv
// rv32i_hazard_ctrl
//   Hazard controller for the 5-stage RV32I pipeline. It handles the hazards
//   that operand forwarding cannot resolve: load-use, taken-branch redirects,
//   multi-cycle MDU ops held in EX, and data-memory wait states. It produces
//   per-stage enable/flush controls for the PC, IF/ID, ID/EX and EX/MEM registers.
//
// Parameters
//   MDU_TIMEOUT : max cycles spent in MDU_BUSY before a forced abort (>= 2)
//   TCW         : width of the timeout counter (must hold MDU_TIMEOUT)
//
// Ports
//   clk, rst_n                 : core clock (rising edge), async active-low reset
//   rs1_id, rs2_id             : source registers of the instruction in ID
//   use_rs1_id, use_rs2_id     : ID instruction actually reads rs1 / rs2
//   rd_ex, memread_ex          : destination register in EX / EX holds a load
//   branch_taken_ex            : EX resolved a taken branch or jump
//   mdu_start_ex, mdu_done     : multi-cycle mul/div launch in EX / result valid pulse
//   dmem_req_mem, dmem_ready   : MEM data access / memory accepts or completes it
//   pc_en, ifid_en, idex_en, exmem_en       : pipeline register enables
//   ifid_flush, idex_flush, exmem_flush     : load NOP / bubble into the register
//   mdu_err                    : 1-cycle pulse after an MDU timeout
//   perf_loaduse, perf_mdu, perf_flush      : 32-bit event counters
//
// Optional feature
//   HAZARD_PERF_CNT_EN : when defined, the perf_* counters are implemented;
//                        otherwise the perf_* ports are tied to zero.

module rv32i_hazard_ctrl #(
    parameter int MDU_TIMEOUT = 64,
    parameter int TCW         = 7
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic [4:0]  rs1_id,
    input  logic [4:0]  rs2_id,
    input  logic        use_rs1_id,
    input  logic        use_rs2_id,
    input  logic [4:0]  rd_ex,
    input  logic        memread_ex,
    input  logic        branch_taken_ex,
    input  logic        mdu_start_ex,
    input  logic        mdu_done,
    input  logic        dmem_req_mem,
    input  logic        dmem_ready,
    output logic        pc_en,
    output logic        ifid_en,
    output logic        ifid_flush,
    output logic        idex_en,
    output logic        idex_flush,
    output logic        exmem_en,
    output logic        exmem_flush,
    output logic        mdu_err,
    output logic [31:0] perf_loaduse,
    output logic [31:0] perf_mdu,
    output logic [31:0] perf_flush
);

    localparam logic [1:0] S_RUN       = 2'd0;
    localparam logic [1:0] S_MDU_BUSY  = 2'd1;
    localparam logic [1:0] S_DMEM_WAIT = 2'd2;

    logic [1:0]     state, state_nxt;
    logic [TCW-1:0] cnt, cnt_nxt;
    logic           err_nxt;
    logic           load_use;
    logic           run_eval;
    logic           fire_lu, fire_br;

    // Raw decoded controls, before the reset override.
    logic pc_en_c, ifid_en_c, idex_en_c, exmem_en_c;
    logic ifid_flush_c, idex_flush_c, exmem_flush_c;

    assign load_use = memread_ex && (rd_ex != 5'd0) &&
                      ((use_rs1_id && (rd_ex == rs1_id)) ||
                       (use_rs2_id && (rd_ex == rs2_id)));

    // The ordinary RUN priority rules are evaluated in RUN and also on the
    // cycle a DMEM wait completes. Any undefined state code is treated as RUN.
    assign run_eval = (state != S_MDU_BUSY) && !((state == S_DMEM_WAIT) && !dmem_ready);

    always_comb begin
        pc_en_c       = 1'b1;
        ifid_en_c     = 1'b1;
        idex_en_c     = 1'b1;
        exmem_en_c    = 1'b1;
        ifid_flush_c  = 1'b0;
        idex_flush_c  = 1'b0;
        exmem_flush_c = 1'b0;
        state_nxt     = state;
        cnt_nxt       = cnt;
        err_nxt       = 1'b0;
        fire_lu       = 1'b0;
        fire_br       = 1'b0;

        if (state == S_MDU_BUSY) begin
            // Front of the pipe is frozen; EX/MEM takes bubbles until the result lands.
            pc_en_c       = 1'b0;
            ifid_en_c     = 1'b0;
            idex_en_c     = 1'b0;
            exmem_flush_c = 1'b1;
            cnt_nxt       = cnt + TCW'(1);
            if (mdu_done) begin
                exmem_flush_c = 1'b0;
                state_nxt     = S_RUN;
                cnt_nxt       = '0;
            end else if (cnt == TCW'(MDU_TIMEOUT - 1)) begin
                // Abort releases the pipe exactly like a completion; error is flagged next cycle.
                exmem_flush_c = 1'b0;
                state_nxt     = S_RUN;
                cnt_nxt       = '0;
                err_nxt       = 1'b1;
            end
        end else if (!run_eval) begin
            pc_en_c    = 1'b0;
            ifid_en_c  = 1'b0;
            idex_en_c  = 1'b0;
            exmem_en_c = 1'b0;
        end else if (dmem_req_mem && !dmem_ready) begin
            pc_en_c    = 1'b0;
            ifid_en_c  = 1'b0;
            idex_en_c  = 1'b0;
            exmem_en_c = 1'b0;
            state_nxt  = S_DMEM_WAIT;
        end else begin
            state_nxt = S_RUN;
            if (branch_taken_ex) begin
                // Redirect squashes the wrong-path instructions, including any LU victim.
                ifid_flush_c = 1'b1;
                idex_flush_c = 1'b1;
                fire_br      = 1'b1;
            end else if (mdu_start_ex) begin
                pc_en_c       = 1'b0;
                ifid_en_c     = 1'b0;
                idex_en_c     = 1'b0;
                exmem_flush_c = 1'b1;
                state_nxt     = S_MDU_BUSY;
                cnt_nxt       = '0;
            end else if (load_use) begin
                // One bubble: hold PC and IF/ID, inject a bubble into ID/EX.
                pc_en_c      = 1'b0;
                ifid_en_c    = 1'b0;
                idex_flush_c = 1'b1;
                fire_lu      = 1'b1;
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state   <= S_RUN;
            cnt     <= '0;
            mdu_err <= 1'b0;
        end else begin
            state   <= state_nxt;
            cnt     <= cnt_nxt;
            mdu_err <= err_nxt;
        end
    end

    // While reset is held the pipeline runs free: enables high, no flushes.
    assign pc_en       = !rst_n || pc_en_c;
    assign ifid_en     = !rst_n || ifid_en_c;
    assign idex_en     = !rst_n || idex_en_c;
    assign exmem_en    = !rst_n || exmem_en_c;
    assign ifid_flush  = rst_n && ifid_flush_c;
    assign idex_flush  = rst_n && idex_flush_c;
    assign exmem_flush = rst_n && exmem_flush_c;

`ifdef HAZARD_PERF_CNT_EN
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            perf_loaduse <= 32'd0;
            perf_mdu     <= 32'd0;
            perf_flush   <= 32'd0;
        end else begin
            if (fire_lu)              perf_loaduse <= perf_loaduse + 32'd1;
            if (state == S_MDU_BUSY)  perf_mdu     <= perf_mdu + 32'd1;
            if (fire_br)              perf_flush   <= perf_flush + 32'd1;
        end
    end
`else
    logic unused_perf;
    assign unused_perf  = fire_lu ^ fire_br;
    assign perf_loaduse = 32'd0;
    assign perf_mdu     = 32'd0;
    assign perf_flush   = 32'd0;
`endif

endmodule

// File: tb/tb_rv32i_hazard_ctrl.sv
// tb_rv32i_hazard_ctrl
//   Directed scenarios followed by randomized traffic, every cycle compared
//   against a behavioural model of the hazard rules kept in this file.

module tb_rv32i_hazard_ctrl;

    localparam int TO = 6;

`ifdef HAZARD_PERF_CNT_EN
    localparam bit PERF_ON = 1'b1;
`else
    localparam bit PERF_ON = 1'b0;
`endif

    logic        clk = 1'b0;
    logic        rst_n;
    logic [4:0]  rs1_id, rs2_id, rd_ex;
    logic        use_rs1_id, use_rs2_id, memread_ex, branch_taken_ex;
    logic        mdu_start_ex, mdu_done, dmem_req_mem, dmem_ready;
    logic        pc_en, ifid_en, ifid_flush, idex_en, idex_flush;
    logic        exmem_en, exmem_flush, mdu_err;
    logic [31:0] perf_loaduse, perf_mdu, perf_flush;

    int checks   = 0;
    int failures = 0;

    // Model state: which stall (if any) is in progress and how long it has run.
    bit m_in_mdu, m_in_dmem, m_err;
    int m_busy;
    int p_lu, p_mdu, p_br;

    always #5 clk = ~clk;

    rv32i_hazard_ctrl #(.MDU_TIMEOUT(TO), .TCW(3)) dut (
        .clk(clk), .rst_n(rst_n),
        .rs1_id(rs1_id), .rs2_id(rs2_id), .use_rs1_id(use_rs1_id), .use_rs2_id(use_rs2_id),
        .rd_ex(rd_ex), .memread_ex(memread_ex), .branch_taken_ex(branch_taken_ex),
        .mdu_start_ex(mdu_start_ex), .mdu_done(mdu_done),
        .dmem_req_mem(dmem_req_mem), .dmem_ready(dmem_ready),
        .pc_en(pc_en), .ifid_en(ifid_en), .ifid_flush(ifid_flush),
        .idex_en(idex_en), .idex_flush(idex_flush),
        .exmem_en(exmem_en), .exmem_flush(exmem_flush), .mdu_err(mdu_err),
        .perf_loaduse(perf_loaduse), .perf_mdu(perf_mdu), .perf_flush(perf_flush)
    );

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s got=%0h exp=%0h @%0t", tag, got, exp, $time);
        end
    endtask

    task automatic idle();
        rs1_id = 5'd0; rs2_id = 5'd0; rd_ex = 5'd0;
        use_rs1_id = 1'b0; use_rs2_id = 1'b0; memread_ex = 1'b0;
        branch_taken_ex = 1'b0; mdu_start_ex = 1'b0; mdu_done = 1'b0;
        dmem_req_mem = 1'b0; dmem_ready = 1'b1;
    endtask

    // One clock: check outputs at the falling edge, advance the model at the rising edge.
    task automatic cyc();
        bit e_pc, e_ifid, e_idex, e_exm, e_ifidf, e_idexf, e_exmf;
        bit lu, n_mdu, n_dmem, n_err, i_lu, i_mdu, i_br;
        int n_busy;
        @(negedge clk);
        if (!rst_n) begin
            m_in_mdu = 0; m_in_dmem = 0; m_busy = 0; m_err = 0;
            p_lu = 0; p_mdu = 0; p_br = 0;
        end
        {e_pc, e_ifid, e_idex, e_exm} = 4'b1111;
        {e_ifidf, e_idexf, e_exmf}    = 3'b000;
        n_mdu = m_in_mdu; n_dmem = m_in_dmem; n_busy = m_busy; n_err = 0;
        i_lu = 0; i_mdu = 0; i_br = 0;
        lu = memread_ex && rd_ex != 0 &&
             ((use_rs1_id && rd_ex == rs1_id) || (use_rs2_id && rd_ex == rs2_id));
        if (!rst_n) begin
            // free-running pipeline while reset is held
        end else if (m_in_mdu) begin
            {e_pc, e_ifid, e_idex} = 3'b000;
            e_exmf = 1; i_mdu = 1; n_busy = m_busy + 1;
            if (mdu_done || m_busy == TO - 1) begin
                e_exmf = 0; n_mdu = 0; n_err = !mdu_done;
            end
        end else if (m_in_dmem && !dmem_ready) begin
            {e_pc, e_ifid, e_idex, e_exm} = 4'b0000;
        end else if (dmem_req_mem && !dmem_ready) begin
            {e_pc, e_ifid, e_idex, e_exm} = 4'b0000;
            n_dmem = 1;
        end else begin
            n_dmem = 0;
            if (branch_taken_ex) begin
                e_ifidf = 1; e_idexf = 1; i_br = 1;
            end else if (mdu_start_ex) begin
                {e_pc, e_ifid, e_idex} = 3'b000;
                e_exmf = 1; n_mdu = 1; n_busy = 0;
            end else if (lu) begin
                e_pc = 0; e_ifid = 0; e_idexf = 1; i_lu = 1;
            end
        end
        chk("pc_en",       32'(pc_en),       32'(e_pc));
        chk("ifid_en",     32'(ifid_en),     32'(e_ifid));
        chk("idex_en",     32'(idex_en),     32'(e_idex));
        chk("exmem_en",    32'(exmem_en),    32'(e_exm));
        chk("ifid_flush",  32'(ifid_flush),  32'(e_ifidf));
        chk("idex_flush",  32'(idex_flush),  32'(e_idexf));
        chk("exmem_flush", 32'(exmem_flush), 32'(e_exmf));
        chk("mdu_err",     32'(mdu_err),     32'(m_err));
        chk("perf_loaduse", perf_loaduse, PERF_ON ? 32'(p_lu)  : 32'd0);
        chk("perf_mdu",     perf_mdu,     PERF_ON ? 32'(p_mdu) : 32'd0);
        chk("perf_flush",   perf_flush,   PERF_ON ? 32'(p_br)  : 32'd0);
        @(posedge clk);
        if (rst_n) begin
            m_in_mdu = n_mdu; m_in_dmem = n_dmem; m_busy = n_busy; m_err = n_err;
            p_lu += int'(i_lu); p_mdu += int'(i_mdu); p_br += int'(i_br);
        end
        #1;
    endtask

    task automatic set_lu(input logic [4:0] rd);
        memread_ex = 1'b1; rd_ex = rd; rs1_id = 5'd5; use_rs1_id = 1'b1;
    endtask

    initial begin
        idle();
        rst_n = 1'b0;
        @(posedge clk); #1;
        cyc(); cyc();                               // reset state
        rst_n = 1'b1;
        cyc();

        // load-use: one bubble, then free once the load leaves EX
        set_lu(5'd5); cyc();
        idle(); cyc();
        set_lu(5'd0); cyc();                        // x0 never stalls
        idle(); cyc();

        // branch masks load-use
        set_lu(5'd5); branch_taken_ex = 1'b1; cyc();
        idle(); cyc();

        // MDU completes after 5 busy cycles
        mdu_start_ex = 1'b1; cyc();
        idle(); repeat (4) cyc();
        mdu_done = 1'b1; cyc();
        idle(); cyc(); cyc();

        // MDU timeout, then error pulse
        mdu_start_ex = 1'b1; cyc();
        idle(); repeat (TO + 3) cyc();

        // done coincides with the timeout cycle
        mdu_start_ex = 1'b1; cyc();
        idle(); repeat (TO - 1) cyc();
        mdu_done = 1'b1; cyc();
        idle(); cyc(); cyc();

        // mdu_done in RUN is ignored
        mdu_done = 1'b1; cyc();
        idle();

        // DMEM wait 3 cycles, ready together with a branch
        dmem_req_mem = 1'b1; dmem_ready = 1'b0; repeat (3) cyc();
        dmem_ready = 1'b1; branch_taken_ex = 1'b1; cyc();
        idle(); cyc();

        // reset pulse during MDU_BUSY
        mdu_start_ex = 1'b1; cyc();
        idle(); cyc(); cyc();
        rst_n = 1'b0; cyc();
        rst_n = 1'b1; repeat (TO + 2) cyc();

        // randomized traffic
        for (int i = 0; i < 3000; i++) begin
            rst_n           = ($urandom_range(0, 199) != 0);
            rd_ex           = 5'($urandom_range(0, 3));
            rs1_id          = 5'($urandom_range(0, 3));
            rs2_id          = 5'($urandom_range(0, 3));
            use_rs1_id      = 1'($urandom_range(0, 1));
            use_rs2_id      = 1'($urandom_range(0, 1));
            memread_ex      = ($urandom_range(0, 2) == 0);
            branch_taken_ex = ($urandom_range(0, 7) == 0);
            mdu_start_ex    = ($urandom_range(0, 9) == 0);
            mdu_done        = ($urandom_range(0, 4) == 0);
            dmem_req_mem    = ($urandom_range(0, 3) == 0);
            dmem_ready      = ($urandom_range(0, 1) == 0);
            cyc();
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
